// File: rtl/d_flipflop.sv
// Parameterisable-width positive-edge D register with asynchronous active-high reset.
// Qn is the combinational complement of the stored value, appended last for positional compatibility.
module d_flipflop #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             Clk,
    input  logic             Rst,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] r_q;

    // Reset wins over any coincident clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= D;
        end
    end

    assign Q  = r_q;
    assign Qn = ~r_q;

endmodule

// File: tb/tb_d_flipflop.sv
// Self-checking bench for d_flipflop: a 1-bit default instance and an 8-bit instance with RST_VAL=8'hA5,
// directed scenarios plus a randomized regression compared against a shadow model every cycle.
module tb_d_flipflop;

    localparam logic [7:0] RSTV8 = 8'hA5;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       d1;
    logic       q1;
    logic       qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    int n_checks;
    int n_errors;

    // Shadow model state
    logic       m1;
    logic [7:0] m8;
    logic       m_valid;

    d_flipflop u_dff1 (
        .Q   (q1),
        .D   (d1),
        .Clk (clk),
        .Rst (rst),
        .Qn  (qn1)
    );

    d_flipflop #(
        .WIDTH   (8),
        .RST_VAL (RSTV8)
    ) u_dff8 (
        .Q   (q8),
        .D   (d8),
        .Clk (clk),
        .Rst (rst),
        .Qn  (qn8)
    );

    // Gated clock source so the reset-only scenario can run with Clk idle at 0.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a reset edge loads RST_VAL at once; a rising clock loads D unless reset is high then.
    always @(posedge rst) begin
        m1      = 1'b0;
        m8      = RSTV8;
        m_valid = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            m1 = 1'b0;
            m8 = RSTV8;
        end else begin
            m1 = d1;
            m8 = d8;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check1("cyc_q1",  q1,  m1);
            check1("cyc_qn1", qn1, ~m1);
            check8("cyc_q8",  q8,  m8);
            check8("cyc_qn8", qn8, ~m8);
        end
    end

    task automatic after_pos();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        n_checks = 0;
        n_errors = 0;
        m_valid  = 1'b0;
        m1       = 1'b0;
        m8       = 8'h00;
        clk_run  = 1'b0;
        rst      = 1'b0;
        d1       = 1'b1;
        d8       = 8'h00;

        // Reset pulse with the clock idle.
        #3;
        rst = 1'b1;
        #1;
        check1("rst_q1",  q1,  1'b0);
        check1("rst_qn1", qn1, 1'b1);
        check8("rst_q8",  q8,  8'hA5);
        check8("rst_qn8", qn8, 8'h5A);
        #9;
        rst = 1'b0;
        #5;
        check1("rel_hold_q1", q1, 1'b0);
        check8("rel_hold_q8", q8, 8'hA5);

        // Capture and one-edge latency.
        d1 = 1'b1;
        d8 = 8'h3C;
        clk_run = 1'b1;
        after_pos();
        check1("cap_q1",  q1,  1'b1);
        check1("cap_qn1", qn1, 1'b0);
        check8("cap_q8",  q8,  8'h3C);
        d1 = 1'b0;
        d8 = 8'hFF;
        @(negedge clk);
        #1;
        check1("mid_q1",  q1, 1'b1);
        check8("fall_q8", q8, 8'h3C);
        after_pos();
        check1("next_q1", q1, 1'b0);
        check8("next_q8", q8, 8'hFF);

        // Reset held across clock edges.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d1 = ~d1;
            d8 = 8'($urandom);
            after_pos();
            check1("hold_q1", q1, 1'b0);
            check8("hold_q8", q8, 8'hA5);
        end

        // Release on the same edge: that edge still resets.
        d1 = 1'b1;
        d8 = 8'h77;
        @(posedge clk);
        rst <= 1'b0;
        #2;
        check1("coin_q1", q1, 1'b0);
        check8("coin_q8", q8, 8'hA5);
        after_pos();
        check1("post_coin_q1", q1, 1'b1);
        check8("post_coin_q8", q8, 8'h77);

        // Asynchronous reset between edges.
        #1;
        rst = 1'b1;
        #1;
        check1("async_q1", q1, 1'b0);
        check8("async_q8", q8, 8'hA5);
        rst = 1'b0;

        // Randomized regression with sparse reset pulses and held resets.
        for (int i = 0; i < 200; i++) begin
            after_pos();
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            r  = int'($urandom_range(0, 19));
            if (r == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end else if (r == 1) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
        end
        after_pos();
        rst = 1'b0;
        after_pos();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
